// File: rtl/pcie_tlp_pkg.sv
// Shared PCIe TLP definitions for the receive path.
// Contents: fmt_type codes for the TLPs the receive engine handles, bit
// offsets of the header fields inside a 64-bit beat (DW0 in [31:0]), the
// receive FSM state encoding and a small fmt_type/length decode helper.
package pcie_tlp_pkg;

    // fmt_type codes (DW0 bits [30:24])
    localparam logic [6:0] MEM_RD = 7'b0000000;   // 3DW memory read
    localparam logic [6:0] MEM_WR = 7'b1000000;   // 3DW memory write with data
    localparam logic [6:0] CPLD   = 7'b1001010;   // completion with data

    // Beat-0 header field offsets
    localparam int FMT_TYPE_LSB = 24;
    localparam int LEN_LSB      = 0;
    localparam int TC_LSB       = 20;
    localparam int TD_BIT       = 15;
    localparam int EP_BIT       = 14;
    localparam int ATTR_LSB     = 12;
    localparam int TAG_LSB      = 40;
    localparam int RID_LSB      = 48;
    localparam int STATUS_LSB   = 45;
    // Completion beat-1 tag offset (DW2 bits [15:8])
    localparam int CPL_TAG_LSB  = 8;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        MRD_H2    = 3'd1,
        WAIT_CPL  = 3'd2,
        MWR_H2    = 3'd3,
        CPLD_H2   = 3'd4,
        CPLD_DATA = 3'd5,
        DISCARD   = 3'd6
    } rx_state_t;

    // True for a single-DW 3DW request of the given fmt_type
    function automatic logic is_single_dw_req(input logic [31:0] dw0, input logic [6:0] code);
        return (dw0[FMT_TYPE_LSB +: 7] == code) && (dw0[LEN_LSB +: 10] == 10'd1);
    endfunction

endpackage

// File: rtl/rx_engine_if.sv
// AXI4-Stream receive interface carrying TLP beats into the receive engine.
// Ports/signals: m_axis_rx_tdata, m_axis_rx_tkeep, m_axis_rx_tlast,
// m_axis_rx_tvalid driven by the master (PCIe core), m_axis_rx_tready
// driven by the slave (receive engine).
interface rx_engine_if #(
    parameter int C_DATA_WIDTH = 64,
    parameter int KEEP_WIDTH   = C_DATA_WIDTH / 8
);
    logic [C_DATA_WIDTH-1:0] m_axis_rx_tdata;
    logic [KEEP_WIDTH-1:0]   m_axis_rx_tkeep;
    logic                    m_axis_rx_tlast;
    logic                    m_axis_rx_tvalid;
    logic                    m_axis_rx_tready;

    modport master (
        output m_axis_rx_tdata, m_axis_rx_tkeep, m_axis_rx_tlast, m_axis_rx_tvalid,
        input  m_axis_rx_tready
    );

    modport slave (
        input  m_axis_rx_tdata, m_axis_rx_tkeep, m_axis_rx_tlast, m_axis_rx_tvalid,
        output m_axis_rx_tready
    );
endinterface

// File: rtl/cpld_dw_packer.sv
// Completion payload packer: pairs payload DWs into 64-bit words and routes
// them to the configuration or user stream.
// Ports: clk/rst; load (first payload DW arrives, goes to hold), pair (data
// beat: emit {lo_dw, hold}, hold <= hi_dw), last/odd (tlast of this beat and
// parity of the completion length), sel_cfg (stream select), lo_dw/hi_dw
// (beat DWs); cfg_data/cfg_valid and user_data/user_valid registered outputs.
module cpld_dw_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        pair,
    input  logic        last,
    input  logic        odd,
    input  logic        sel_cfg,
    input  logic [31:0] lo_dw,
    input  logic [31:0] hi_dw,
    output logic [63:0] cfg_data,
    output logic        cfg_valid,
    output logic [63:0] user_data,
    output logic        user_valid
);
    logic [31:0] hold_r;
    logic        pend_r;
    logic [63:0] cfg_data_r, user_data_r;
    logic        cfg_valid_r, user_valid_r;
    logic [63:0] word_s;
    logic        emit_s;

    // Word to emit this cycle: a fresh pair, or the odd-length residue one cycle after tlast
    always_comb begin
        word_s = 64'd0;
        emit_s = 1'b0;
        if (pair) begin
            word_s = {lo_dw, hold_r};
            emit_s = 1'b1;
        end else if (pend_r) begin
            word_s = {32'h0000_0000, hold_r};
            emit_s = 1'b1;
        end else begin
            word_s = 64'd0;
            emit_s = 1'b0;
        end
    end

    // Hold register, residue flag and routed output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_r       <= 32'd0;
            pend_r       <= 1'b0;
            cfg_data_r   <= 64'd0;
            user_data_r  <= 64'd0;
            cfg_valid_r  <= 1'b0;
            user_valid_r <= 1'b0;
        end else begin
            // An odd length always leaves the final DW in hold when tlast arrives
            pend_r       <= (load | pair) & last & odd;
            cfg_valid_r  <= emit_s & sel_cfg;
            user_valid_r <= emit_s & ~sel_cfg;
            if (load | pair) begin
                hold_r <= hi_dw;
            end
            if (emit_s & sel_cfg) begin
                cfg_data_r <= word_s;
            end
            if (emit_s & ~sel_cfg) begin
                user_data_r <= word_s;
            end
        end
    end

    assign cfg_data   = cfg_data_r;
    assign cfg_valid  = cfg_valid_r;
    assign user_data  = user_data_r;
    assign user_valid = user_valid_r;
endmodule

// File: rtl/rx_engine.sv
// PCIe receive engine: decodes single-DW MRd/MWr requests and CplD TLPs.
// Ports: clk_i/rst_i; m_axis_rx (slave stream); req_* captured MRd header
// and completion-with-data request handshake (req_compl_wd_o/compl_done_i);
// reg_addr_o/reg_wr_o/reg_data_o register write port; cfg_dma_tag_i selects
// the configuration stream; cfg_data*/user_data* routed completion payload;
// cpld_err_o pulses on a completion with non-zero status.
module rx_engine
    import pcie_tlp_pkg::*;
#(
    parameter int C_DATA_WIDTH = 64,
    parameter int KEEP_WIDTH   = C_DATA_WIDTH / 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    rx_engine_if.slave  m_axis_rx,
    output logic        req_compl_wd_o,
    input  logic        compl_done_i,
    output logic [2:0]  req_tc_o,
    output logic        req_td_o,
    output logic        req_ep_o,
    output logic [1:0]  req_attr_o,
    output logic [9:0]  req_len_o,
    output logic [15:0] req_rid_o,
    output logic [7:0]  req_tag_o,
    output logic [6:0]  req_addr_o,
    output logic [7:0]  reg_addr_o,
    output logic        reg_wr_o,
    output logic [31:0] reg_data_o,
    input  logic [7:0]  cfg_dma_tag_i,
    output logic [63:0] cfg_data_o,
    output logic        cfg_data_valid_o,
    output logic [63:0] user_data_o,
    output logic        user_data_valid_o,
    output logic        cpld_err_o
);
    rx_state_t state_r;
    logic        tready_r, compl_wd_r, reg_wr_r, cpld_err_r, sel_cfg_r;
    logic [2:0]  tc_r, status_r;
    logic        td_r, ep_r;
    logic [1:0]  attr_r;
    logic [9:0]  len_r, cpl_len_r, rem_r;
    logic [15:0] rid_r;
    logic [7:0]  tag_r, reg_addr_r;
    logic [6:0]  req_addr_r;
    logic [31:0] reg_data_r;

    logic [C_DATA_WIDTH-1:0] beat_s;
    logic [KEEP_WIDTH-1:0]   keep_unused_s;
    logic                    beat_unused_s;
    logic                    accept_s, last_s, load_s, pair_s;

    assign beat_s        = m_axis_rx.m_axis_rx_tdata;
    // Packing follows the length field, so tkeep and reserved header bits are not consulted
    assign keep_unused_s = m_axis_rx.m_axis_rx_tkeep;
    assign beat_unused_s = ^beat_s;
    assign last_s        = m_axis_rx.m_axis_rx_tlast;
    assign accept_s      = m_axis_rx.m_axis_rx_tvalid & tready_r;
    assign load_s        = accept_s && (state_r == CPLD_H2) && (status_r == 3'd0);
    assign pair_s        = accept_s && (state_r == CPLD_DATA);

    // Receive FSM with all control/header outputs registered
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r    <= IDLE;
            tready_r   <= 1'b0;
            compl_wd_r <= 1'b0;
            reg_wr_r   <= 1'b0;
            cpld_err_r <= 1'b0;
            sel_cfg_r  <= 1'b0;
            tc_r       <= 3'd0;
            td_r       <= 1'b0;
            ep_r       <= 1'b0;
            attr_r     <= 2'd0;
            len_r      <= 10'd0;
            rid_r      <= 16'd0;
            tag_r      <= 8'd0;
            req_addr_r <= 7'd0;
            reg_addr_r <= 8'd0;
            reg_data_r <= 32'd0;
            status_r   <= 3'd0;
            cpl_len_r  <= 10'd0;
            rem_r      <= 10'd0;
        end else begin
            tready_r   <= 1'b1;
            reg_wr_r   <= 1'b0;
            cpld_err_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        if (last_s) begin
                            state_r <= IDLE;
                        end else if (is_single_dw_req(beat_s[31:0], MEM_RD)) begin
                            tc_r    <= beat_s[TC_LSB +: 3];
                            td_r    <= beat_s[TD_BIT];
                            ep_r    <= beat_s[EP_BIT];
                            attr_r  <= beat_s[ATTR_LSB +: 2];
                            len_r   <= beat_s[LEN_LSB +: 10];
                            rid_r   <= beat_s[RID_LSB +: 16];
                            tag_r   <= beat_s[TAG_LSB +: 8];
                            state_r <= MRD_H2;
                        end else if (is_single_dw_req(beat_s[31:0], MEM_WR)) begin
                            state_r <= MWR_H2;
                        end else if (beat_s[FMT_TYPE_LSB +: 7] == CPLD) begin
                            status_r  <= beat_s[STATUS_LSB +: 3];
                            cpl_len_r <= beat_s[LEN_LSB +: 10];
                            state_r   <= CPLD_H2;
                        end else begin
                            state_r <= DISCARD;
                        end
                    end
                end
                MRD_H2: begin
                    if (accept_s) begin
                        req_addr_r <= beat_s[6:0];
                        reg_addr_r <= beat_s[9:2];
                        compl_wd_r <= 1'b1;
                        tready_r   <= 1'b0;
                        state_r    <= WAIT_CPL;
                    end
                end
                WAIT_CPL: begin
                    if (compl_done_i) begin
                        compl_wd_r <= 1'b0;
                        state_r    <= IDLE;
                    end else begin
                        tready_r <= 1'b0;
                    end
                end
                MWR_H2: begin
                    if (accept_s) begin
                        reg_addr_r <= beat_s[9:2];
                        reg_data_r <= beat_s[63:32];
                        reg_wr_r   <= 1'b1;
                        state_r    <= last_s ? IDLE : DISCARD;
                    end
                end
                CPLD_H2: begin
                    if (accept_s) begin
                        sel_cfg_r <= (beat_s[CPL_TAG_LSB +: 8] == cfg_dma_tag_i);
                        // Length 0 encodes 1024 DWs; the 10-bit wrap of 0 - 1 yields 1023
                        rem_r     <= cpl_len_r - 10'd1;
                        if (status_r != 3'd0) begin
                            cpld_err_r <= 1'b1;
                            state_r    <= last_s ? IDLE : DISCARD;
                        end else begin
                            state_r <= last_s ? IDLE : CPLD_DATA;
                        end
                    end
                end
                CPLD_DATA: begin
                    if (accept_s) begin
                        rem_r <= rem_r - 10'd2;
                        if (last_s) begin
                            state_r <= IDLE;
                        end else if (rem_r <= 10'd2) begin
                            // Payload exhausted but the packet continues: drop the excess
                            state_r <= DISCARD;
                        end else begin
                            state_r <= CPLD_DATA;
                        end
                    end
                end
                DISCARD: begin
                    if (accept_s && last_s) begin
                        state_r <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    cpld_dw_packer u_packer (
        .clk        (clk_i),
        .rst        (rst_i),
        .load       (load_s),
        .pair       (pair_s),
        .last       (last_s),
        .odd        (cpl_len_r[0]),
        .sel_cfg    (sel_cfg_r),
        .lo_dw      (beat_s[31:0]),
        .hi_dw      (beat_s[63:32]),
        .cfg_data   (cfg_data_o),
        .cfg_valid  (cfg_data_valid_o),
        .user_data  (user_data_o),
        .user_valid (user_data_valid_o)
    );

    assign m_axis_rx.m_axis_rx_tready = tready_r;
    assign req_compl_wd_o = compl_wd_r;
    assign req_tc_o       = tc_r;
    assign req_td_o       = td_r;
    assign req_ep_o       = ep_r;
    assign req_attr_o     = attr_r;
    assign req_len_o      = len_r;
    assign req_rid_o      = rid_r;
    assign req_tag_o      = tag_r;
    assign req_addr_o     = req_addr_r;
    assign reg_addr_o     = reg_addr_r;
    assign reg_wr_o       = reg_wr_r;
    assign reg_data_o     = reg_data_r;
    assign cpld_err_o     = cpld_err_r;
endmodule

// File: tb/tb_rx_engine.sv
// Self-checking bench for rx_engine: scoreboard queues filled when TLPs are
// driven, drained by a negedge monitor as the DUT produces output.
module tb_rx_engine;
    import pcie_tlp_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rx_engine_if #(.C_DATA_WIDTH(64)) axis ();

    logic        compl_done;
    logic [7:0]  cfg_dma_tag;
    logic        req_compl_wd, req_td, req_ep, reg_wr;
    logic [2:0]  req_tc;
    logic [1:0]  req_attr;
    logic [9:0]  req_len;
    logic [15:0] req_rid;
    logic [7:0]  req_tag, reg_addr;
    logic [6:0]  req_addr;
    logic [31:0] reg_data;
    logic [63:0] cfg_data, user_data;
    logic        cfg_data_valid, user_data_valid, cpld_err;

    rx_engine #(.C_DATA_WIDTH(64)) dut (
        .clk_i(clk), .rst_i(rst), .m_axis_rx(axis),
        .req_compl_wd_o(req_compl_wd), .compl_done_i(compl_done),
        .req_tc_o(req_tc), .req_td_o(req_td), .req_ep_o(req_ep), .req_attr_o(req_attr),
        .req_len_o(req_len), .req_rid_o(req_rid), .req_tag_o(req_tag), .req_addr_o(req_addr),
        .reg_addr_o(reg_addr), .reg_wr_o(reg_wr), .reg_data_o(reg_data),
        .cfg_dma_tag_i(cfg_dma_tag),
        .cfg_data_o(cfg_data), .cfg_data_valid_o(cfg_data_valid),
        .user_data_o(user_data), .user_data_valid_o(user_data_valid),
        .cpld_err_o(cpld_err)
    );

    int errors = 0;
    int checks = 0;
    logic [63:0] cfg_q[$];
    logic [63:0] user_q[$];
    logic [39:0] wr_q[$];
    int          err_exp = 0;
    logic [63:0] mon_exp64;
    logic [39:0] mon_exp40;

    // Scoreboard monitor: every output event must match the head of its queue
    always @(negedge clk) begin
        if (cfg_data_valid) begin
            checks++;
            if (cfg_q.size() == 0) begin
                errors++;
                $display("FAIL cfg_unexpected: got %h, required no output", cfg_data);
            end else begin
                mon_exp64 = cfg_q.pop_front();
                if (cfg_data !== mon_exp64) begin
                    errors++;
                    $display("FAIL cfg_data: got %h, required %h", cfg_data, mon_exp64);
                end
            end
        end
        if (user_data_valid) begin
            checks++;
            if (user_q.size() == 0) begin
                errors++;
                $display("FAIL user_unexpected: got %h, required no output", user_data);
            end else begin
                mon_exp64 = user_q.pop_front();
                if (user_data !== mon_exp64) begin
                    errors++;
                    $display("FAIL user_data: got %h, required %h", user_data, mon_exp64);
                end
            end
        end
        if (reg_wr) begin
            checks++;
            if (wr_q.size() == 0) begin
                errors++;
                $display("FAIL reg_wr_unexpected: got addr %h data %h, required no write", reg_addr, reg_data);
            end else begin
                mon_exp40 = wr_q.pop_front();
                if ({reg_addr, reg_data} !== mon_exp40) begin
                    errors++;
                    $display("FAIL reg_write: got %h, required %h", {reg_addr, reg_data}, mon_exp40);
                end
            end
        end
        if (cpld_err) begin
            checks++;
            if (err_exp == 0) begin
                errors++;
                $display("FAIL cpld_err_unexpected: got 1, required 0");
            end else begin
                err_exp--;
            end
        end
    end

    function automatic logic [31:0] mk_dw0(input logic [6:0] fmt, input logic [2:0] tc,
                                           input logic td, input logic ep,
                                           input logic [1:0] attr, input logic [9:0] len);
        return {1'b0, fmt, 1'b0, tc, 4'b0000, td, ep, attr, 2'b00, len};
    endfunction

    task automatic send_beat(input logic [63:0] data, input logic last);
        int  waited;
        bit  done;
        waited = 0;
        done   = 1'b0;
        axis.m_axis_rx_tdata  = data;
        axis.m_axis_rx_tkeep  = 8'hFF;
        axis.m_axis_rx_tlast  = last;
        axis.m_axis_rx_tvalid = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (axis.m_axis_rx_tready === 1'b1) begin
                done = 1'b1;
            end else begin
                waited++;
                if (waited > 50) begin
                    checks++;
                    errors++;
                    $display("FAIL beat_accept_timeout: tready %b, required 1", axis.m_axis_rx_tready);
                    done = 1'b1;
                end
            end
            @(posedge clk);
            #1;
        end
        axis.m_axis_rx_tvalid = 1'b0;
        axis.m_axis_rx_tlast  = 1'b0;
    endtask

    task automatic send_mwr(input logic [31:0] addr, input logic [31:0] data);
        wr_q.push_back({addr[9:2], data});
        send_beat({16'h0100, 8'h00, 8'h0F, mk_dw0(MEM_WR, 3'd0, 1'b0, 1'b0, 2'd0, 10'd1)}, 1'b0);
        send_beat({data, addr}, 1'b1);
    endtask

    task automatic send_cpld(input logic [9:0] n, input logic [2:0] status, input logic [7:0] tag,
                             input logic to_cfg, input logic [31:0] base);
        int          ndw;
        logic [31:0] w[$];
        logic [31:0] hi;
        logic [63:0] word;
        ndw = (n == 10'd0) ? 1024 : int'(n);
        for (int i = 0; i < ndw; i++) w.push_back(base + 32'(i));
        if (status == 3'b000) begin
            for (int j = 0; j < ndw / 2; j++) begin
                word = {w[2*j+1], w[2*j]};
                if (to_cfg) cfg_q.push_back(word); else user_q.push_back(word);
            end
            if (ndw % 2 == 1) begin
                word = {32'h0000_0000, w[ndw-1]};
                if (to_cfg) cfg_q.push_back(word); else user_q.push_back(word);
            end
        end else begin
            err_exp++;
        end
        send_beat({16'h0200, status, 1'b0, 12'(ndw * 4), mk_dw0(CPLD, 3'd0, 1'b0, 1'b0, 2'd0, n)}, 1'b0);
        send_beat({w[0], 16'h0300, tag, 8'h00}, ndw == 1);
        for (int k = 2; k < 2 + ndw / 2; k++) begin
            hi = (2*k - 2 < ndw) ? w[2*k-2] : 32'hBAD0_0000;
            send_beat({hi, w[2*k-3]}, k == 1 + ndw / 2);
        end
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((cfg_q.size() + user_q.size() + wr_q.size() + err_exp) != 0 && n < 10) begin
            @(posedge clk);
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ((cfg_q.size() + user_q.size() + wr_q.size() + err_exp) != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d outputs outstanding, required 0", name,
                     cfg_q.size() + user_q.size() + wr_q.size() + err_exp);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (axis.m_axis_rx_tready !== 1'b0) begin
            errors++; $display("FAIL reset_tready: got %b, required 0", axis.m_axis_rx_tready);
        end
        checks++;
        if ({req_compl_wd, reg_wr, cfg_data_valid, user_data_valid, cpld_err} !== 5'b0) begin
            errors++; $display("FAIL reset_strobes: got %b, required 0",
                               {req_compl_wd, reg_wr, cfg_data_valid, user_data_valid, cpld_err});
        end
        checks++;
        if ({req_tc, req_td, req_ep, req_attr, req_len, req_rid, req_tag, req_addr} !== 48'd0) begin
            errors++; $display("FAIL reset_header: got %h, required 0",
                               {req_tc, req_td, req_ep, req_attr, req_len, req_rid, req_tag, req_addr});
        end
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (axis.m_axis_rx_tready !== 1'b1) begin
            errors++; $display("FAIL post_reset_tready: got %b, required 1", axis.m_axis_rx_tready);
        end
    endtask

    task automatic test_mrd();
        send_beat({16'h0100, 8'h05, 8'h0F, mk_dw0(MEM_RD, 3'b010, 1'b1, 1'b0, 2'b01, 10'd1)}, 1'b0);
        send_beat({32'h0000_0000, 32'h0000_0014}, 1'b1);
        checks++;
        if ({req_compl_wd, req_addr, reg_addr, axis.m_axis_rx_tready} !== {1'b1, 7'h14, 8'h05, 1'b0}) begin
            errors++; $display("FAIL mrd_request: got wd %b addr %h reg %h tready %b, required 1 14 05 0",
                               req_compl_wd, req_addr, reg_addr, axis.m_axis_rx_tready);
        end
        checks++;
        if ({req_tc, req_td, req_ep, req_attr, req_len, req_rid, req_tag} !==
            {3'b010, 1'b1, 1'b0, 2'b01, 10'd1, 16'h0100, 8'h05}) begin
            errors++; $display("FAIL mrd_header: got tc %h td %b ep %b attr %h len %h rid %h tag %h, required 2 1 0 1 001 0100 05",
                               req_tc, req_td, req_ep, req_attr, req_len, req_rid, req_tag);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({req_compl_wd, axis.m_axis_rx_tready} !== 2'b10) begin
            errors++; $display("FAIL mrd_hold: got wd %b tready %b, required 1 0", req_compl_wd, axis.m_axis_rx_tready);
        end
        @(posedge clk);
        #1 compl_done = 1'b1;
        @(posedge clk);
        #1 compl_done = 1'b0;
        checks++;
        if ({req_compl_wd, axis.m_axis_rx_tready} !== 2'b01) begin
            errors++; $display("FAIL mrd_done: got wd %b tready %b, required 0 1", req_compl_wd, axis.m_axis_rx_tready);
        end
    endtask

    task automatic test_mwr();
        send_mwr(32'h0000_0008, 32'hDEADBEEF);
        wait_drain("mwr");
    endtask

    task automatic test_cpld_cfg();
        send_cpld(10'd4, 3'b000, 8'h2A, 1'b1, 32'hA000_0000);
        wait_drain("cpld_cfg");
    endtask

    task automatic test_back_to_back();
        send_cpld(10'd3, 3'b000, 8'h11, 1'b0, 32'hB000_0000);
        send_mwr(32'h0000_000C, 32'h1234_5678);
        send_cpld(10'd1, 3'b000, 8'h2A, 1'b1, 32'hC000_0000);
        send_cpld(10'd2, 3'b000, 8'h33, 1'b0, 32'hD000_0000);
        send_cpld(10'd5, 3'b000, 8'h2A, 1'b1, 32'hE000_0000);
        wait_drain("back_to_back");
    endtask

    task automatic test_cpld_err();
        send_cpld(10'd2, 3'b001, 8'h2A, 1'b1, 32'hF000_0000);
        send_mwr(32'h0000_0010, 32'hCAFE_F00D);
        wait_drain("cpld_err");
    endtask

    task automatic test_discard_reset();
        send_beat({32'h0000_0000, mk_dw0(7'b1100000, 3'd0, 1'b0, 1'b0, 2'd0, 10'd1)}, 1'b0);
        send_beat({32'h0000_0020, 32'h0000_0001}, 1'b0);
        send_beat({32'h0000_0000, 32'h5555_AAAA}, 1'b1);
        send_beat({16'h0200, 3'b000, 1'b0, 12'd16, mk_dw0(CPLD, 3'd0, 1'b0, 1'b0, 2'd0, 10'd4)}, 1'b0);
        send_beat({32'h7777_0000, 16'h0300, 8'h2A, 8'h00}, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({axis.m_axis_rx_tready, req_compl_wd, reg_wr, cfg_data_valid, user_data_valid, cpld_err} !== 6'b0) begin
            errors++; $display("FAIL midpkt_reset_strobes: got %b, required 0",
                               {axis.m_axis_rx_tready, req_compl_wd, reg_wr, cfg_data_valid, user_data_valid, cpld_err});
        end
        checks++;
        if ({cfg_data, user_data, reg_data, reg_addr} !== 168'd0) begin
            errors++; $display("FAIL midpkt_reset_data: got %h %h %h %h, required 0", cfg_data, user_data, reg_data, reg_addr);
        end
        checks++;
        if ({req_tc, req_td, req_ep, req_attr, req_len, req_rid, req_tag, req_addr} !== 48'd0) begin
            errors++; $display("FAIL midpkt_reset_header: got %h, required 0",
                               {req_tc, req_td, req_ep, req_attr, req_len, req_rid, req_tag, req_addr});
        end
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (axis.m_axis_rx_tready !== 1'b1) begin
            errors++; $display("FAIL release_tready: got %b, required 1", axis.m_axis_rx_tready);
        end
        send_mwr(32'h0000_00FC, 32'h0BAD_C0DE);
        wait_drain("discard_reset");
    endtask

    initial begin
        rst                   = 1'b1;
        compl_done            = 1'b0;
        cfg_dma_tag           = 8'h2A;
        axis.m_axis_rx_tdata  = 64'd0;
        axis.m_axis_rx_tkeep  = 8'h00;
        axis.m_axis_rx_tlast  = 1'b0;
        axis.m_axis_rx_tvalid = 1'b0;
        test_reset();
        test_mrd();
        test_mwr();
        test_cpld_cfg();
        test_back_to_back();
        test_cpld_err();
        test_discard_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/rx_engine.md
RX_ENGINE -- requirements
Module: rx_engine

Interface
REQ-001 Parameter C_DATA_WIDTH, default 64, sets the AXIS data width; parameter KEEP_WIDTH, default C_DATA_WIDTH/8, sets the keep width.
REQ-002 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-003 clk_i  in  1  sole clock, all logic on its rising edge.
REQ-004 rst_i  in  1  asynchronous active-high reset.
REQ-005 m_axis_rx_tdata in 64, m_axis_rx_tkeep in 8, m_axis_rx_tlast in 1, m_axis_rx_tvalid in 1  received TLP stream; DW0 in [31:0].
REQ-006 m_axis_rx_tready  out  1  beat accept.
REQ-007 req_compl_wd_o  out  1  completion-with-data request to the transmit engine; compl_done_i  in  1  transmit engine done.
REQ-008 req_tc_o 3, req_td_o 1, req_ep_o 1, req_attr_o 2, req_len_o 10, req_rid_o 16, req_tag_o 8, req_addr_o 7  out  captured memory-read header fields.
REQ-009 reg_addr_o  out  8  register DW address; reg_wr_o  out  1  write strobe; reg_data_o  out  32  write data.
REQ-010 cfg_dma_tag_i  in  8  tag of the outstanding configuration DMA read.
REQ-011 cfg_data_o 64 / cfg_data_valid_o 1, user_data_o 64 / user_data_valid_o 1  out  routed completion payload; no backpressure.
REQ-012 cpld_err_o  out  1  one-cycle pulse on a completion with non-zero status.

Function
REQ-013 A beat SHALL be accepted when tvalid and tready are both high; tready SHALL be 1 in every state except WAIT_CPL.
REQ-014 States: IDLE, MRD_H2, WAIT_CPL, MWR_H2, CPLD_H2, CPLD_DATA, DISCARD.
REQ-015 IDLE, beat0 decode fmt_type=tdata[30:24] and len=tdata[9:0]: 7'b0000000 with len=1 -> MRD_H2; 7'b1000000 with len=1 -> MWR_H2; 7'b1001010 -> CPLD_H2; anything else (4DW, other types, len!=1 MRd/MWr) -> DISCARD, or stay IDLE if tlast.
REQ-016 On MRd beat0, capture tc=[22:20], td=[15], ep=[14], attr=[13:12], len=[9:0], rid=[63:48], tag=[47:40].
REQ-017 MRD_H2 beat: req_addr_o=tdata[6:0] and reg_addr_o=tdata[9:2]; req_compl_wd_o=1 on the next clock; -> WAIT_CPL.
REQ-018 WAIT_CPL: req_compl_wd_o held 1 until compl_done_i=1 is sampled; the next clock drives req_compl_wd_o=0 -> IDLE.
REQ-019 MWR_H2 beat: reg_addr_o=tdata[9:2], reg_data_o=tdata[63:32], reg_wr_o=1 for exactly one cycle on the next clock; -> IDLE.
REQ-020 CplD beat0: capture status=tdata[47:45] and N=len (0 means 1024).
REQ-021 CplD beat1: tag=tdata[15:8]; stream=cfg if tag==cfg_dma_tag_i, else user; hold<=tdata[63:32]; rem<=N-1.
REQ-022 If status!=0: cpld_err_o pulses, no payload is emitted, -> DISCARD (IDLE if tlast).
REQ-023 CPLD_DATA, each beat: emit {tdata[31:0],hold} with the selected valid high for one cycle, next clock; hold<=tdata[63:32]; rem-=2.
REQ-024 Packing follows N parity, not tkeep: odd N leaves hold pending at tlast, and {32'h0,hold} SHALL be emitted the cycle after tlast, including N=1; even N leaves no residue.
REQ-025 DISCARD consumes beats until tlast, then -> IDLE, with no outputs.
REQ-026 Back-to-back TLPs: a new beat0 is accepted the cycle after tlast; the odd-N flush SHALL overlap it without loss.
REQ-027 Output latency SHALL be 1 clock from beat acceptance for every registered output.

Reset
REQ-028 rst_i high: state=IDLE; tready=0; all outputs 0 (data, address, header fields, strobes, valids); hold, rem and the stream select are cleared.
REQ-029 Reset mid-packet drops the packet; after reset release, the block resumes in IDLE expecting a beat0.

Structure
REQ-030 Shared package pcie_tlp_pkg: fmt_type codes MEM_RD=7'b0000000, MEM_WR=7'b1000000, CPLD=7'b1001010; header field bit offsets; state encoding.
REQ-031 One sub-module, cpld_dw_packer: hold register, DW pairing and odd-N flush.

Verification
REQ-032 MRd len=1, tag 8'h05, rid 16'h0100, addr 0x14 -> req_compl_wd_o=1 with req_addr_o=7'h14, reg_addr_o=8'h05, tready=0; compl_done_i pulse -> req_compl_wd_o=0, then IDLE.
REQ-033 MWr addr 0x08, data 32'hDEADBEEF -> single reg_wr_o pulse, reg_addr_o=8'h02, reg_data_o=32'hDEADBEEF.
REQ-034 CplD N=4, tag==cfg_dma_tag_i, payload DWs A,B,C,D -> cfg_data_o {B,A} then {D,C}; user_data_valid_o stays 0.
REQ-035 CplD N=3 on the user tag, immediately followed by MWr -> user words {B,A} then {0,C}; the MWr strobe is correct and nothing is lost.
REQ-036 CplD status 3'b001 -> one cpld_err_o pulse, no valid asserted; next TLP decodes normally.
REQ-037 4DW MWr, then rst_i asserted mid-CplD -> no outputs; all outputs 0 during reset; IDLE after release.
